// File: rtl/gameport_pkg.sv
// Shared types and constants for the game-port CPU front end.
package gameport_pkg;
    typedef enum logic [1:0] {GP_IDLE, GP_PULSE, GP_GAP} gp_state_t;
    localparam int         GP_AXIS_BITS = 4;
    localparam logic [7:0] GP_FLOAT     = 8'hFF;
endpackage

// File: rtl/gameport_trigger_fsm.sv
// Trigger pulse generator for the joystick one-shots plus the per-axis timeout mask.
//   state    | meaning
//   GP_IDLE  | joy_en low, waiting for a CPU write
//   GP_PULSE | joy_en high for EN_WIDTH clocks
//   GP_GAP   | joy_en forced low GAP_WIDTH clocks before a re-trigger pulse
module gameport_trigger_fsm
    import gameport_pkg::*;
#(
    parameter int EN_WIDTH  = 8,
    parameter int GAP_WIDTH = 2,
    parameter int TIMEOUT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_start,
    input  logic [GP_AXIS_BITS-1:0] joy_axes,
    output logic                    joy_en,
    output logic [GP_AXIS_BITS-1:0] axis_mask
);
    localparam logic [7:0]  EN_LAST  = 8'(EN_WIDTH - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_WIDTH - 1);
    localparam logic [23:0] TO_LIMIT = 24'(TIMEOUT);
    localparam logic        TO_ON    = (TIMEOUT != 0);

    gp_state_t               state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [23:0]             tcnt_q, tcnt_d;
    logic [GP_AXIS_BITS-1:0] axis_mask_q, axis_mask_d;
    logic                    armed_q, armed_d;
    logic                    joy_en_q, joy_en_d;
    logic                    trig;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GP_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            axis_mask_q <= '0;
            armed_q     <= 1'b0;
            joy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            axis_mask_q <= axis_mask_d;
            armed_q     <= armed_d;
            joy_en_q    <= joy_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig    = 1'b0;
        case (state_q)
            GP_IDLE: begin
                if (wr_start) begin
                    state_d = GP_PULSE;
                    cnt_d   = '0;
                    trig    = 1'b1;
                end
            end
            GP_PULSE: begin
                if (wr_start) begin
                    state_d = GP_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == EN_LAST) begin
                    state_d = GP_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GP_GAP: begin
                // writes arriving here are absorbed into the pending pulse
                if (cnt_q == GAP_LAST) begin
                    state_d = GP_PULSE;
                    cnt_d   = '0;
                    trig    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = GP_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        joy_en_d    = (state_d == GP_PULSE);
        tcnt_d      = tcnt_q;
        axis_mask_d = axis_mask_q;
        armed_d     = armed_q;
        if (trig) begin
            tcnt_d      = '0;
            axis_mask_d = '0;
            armed_d     = TO_ON;
        end else begin
            if (tcnt_q != TO_LIMIT)
                tcnt_d = tcnt_q + 24'd1;
            // latch once per trigger: axes still high at timeout are treated as absent
            if (armed_q && (tcnt_q == TO_LIMIT)) begin
                axis_mask_d = joy_axes;
                armed_d     = 1'b0;
            end
        end
    end

    assign joy_en    = joy_en_q;
    assign axis_mask = axis_mask_q;
endmodule

// File: rtl/gameport_bus_if.sv
// CPU I/O decode, cycle edge detection and read snapshot for the analog joystick port.
module gameport_bus_if
    import gameport_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0200,
    parameter logic [15:0] ADDR_MASK = 16'hFFF8,
    parameter int          EN_WIDTH  = 8,
    parameter int          GAP_WIDTH = 2,
    parameter int          TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] io_addr,
    input  logic        io_read,
    input  logic        io_write,
    output logic [7:0]  io_rdata,
    output logic        io_rdata_oe,
    input  logic [7:0]  joy_d,
    output logic        joy_en,
    output logic        busy
);
    logic                    hit, rd_start, wr_start;
    logic                    io_read_q, io_read_d;
    logic                    io_write_q, io_write_d;
    logic                    oe_q, oe_d;
    logic [7:0]              snapshot_q, snapshot_d;
    logic                    triggered_q, triggered_d;
    logic [GP_AXIS_BITS-1:0] axis_mask;
    logic [GP_AXIS_BITS-1:0] unmasked;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_read_q   <= 1'b0;
            io_write_q  <= 1'b0;
            oe_q        <= 1'b0;
            snapshot_q  <= GP_FLOAT;
            triggered_q <= 1'b0;
        end else begin
            io_read_q   <= io_read_d;
            io_write_q  <= io_write_d;
            oe_q        <= oe_d;
            snapshot_q  <= snapshot_d;
            triggered_q <= triggered_d;
        end
    end

    always_comb begin
        hit         = enable && ((io_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
        rd_start    = io_read && !io_read_q && hit;
        wr_start    = io_write && !io_write_q && hit;
        io_read_d   = io_read;
        io_write_d  = io_write;
        unmasked    = joy_d[GP_AXIS_BITS-1:0] & ~axis_mask;
        // snapshot uses the pre-trigger mask when a read and write start together
        snapshot_d  = rd_start ? {joy_d[7:GP_AXIS_BITS], unmasked} : snapshot_q;
        oe_d        = rd_start || (oe_q && io_read && hit);
        triggered_d = triggered_q || wr_start;
    end

    gameport_trigger_fsm #(
        .EN_WIDTH (EN_WIDTH),
        .GAP_WIDTH(GAP_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) u_trigger_fsm (
        .clk      (clk),
        .reset    (reset),
        .wr_start (wr_start),
        .joy_axes (joy_d[GP_AXIS_BITS-1:0]),
        .joy_en   (joy_en),
        .axis_mask(axis_mask)
    );

    assign io_rdata_oe = oe_q;
    assign io_rdata    = oe_q ? snapshot_q : GP_FLOAT;
    assign busy        = triggered_q && (|unmasked);
endmodule

// File: tb/tb_gameport_bus_if.sv
// Directed bench for gameport_bus_if: decode, read snapshot, trigger pulses and axis timeout.
module tb_gameport_bus_if;
    logic        clk = 1'b0;
    logic        reset, enable, io_read, io_write;
    logic [15:0] io_addr;
    logic [7:0]  joy_d;
    logic [7:0]  io_rdata;
    logic        io_rdata_oe, joy_en, busy;
    logic [39:0] pat;
    int          n_pass = 0;
    int          n_total = 0;

    always #10 clk = ~clk;

    gameport_bus_if #(
        .BASE_ADDR(16'h0200),
        .ADDR_MASK(16'hFFF8),
        .EN_WIDTH (8),
        .GAP_WIDTH(2),
        .TIMEOUT  (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .io_addr    (io_addr),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_rdata   (io_rdata),
        .io_rdata_oe(io_rdata_oe),
        .joy_d      (joy_d),
        .joy_en     (joy_en),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; io_read = 1'b0; io_write = 1'b0;
        io_addr = 16'h0201; joy_d = 8'hA5;
        steps(3);
        check("rst_rdata", 40'(io_rdata), 40'hFF);
        check("rst_oe", 40'(io_rdata_oe), 40'd0);
        check("rst_joy_en", 40'(joy_en), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        reset = 1'b0;
        step();

        // 20-clock read of 0x201
        io_read = 1'b1;
        pat = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            pat[i] = io_rdata_oe;
            if (i == 1 || i == 20) check("read_data", 40'(io_rdata), 40'hA5);
        end
        check("read_oe_window", pat, 40'h00_001F_FFFE);
        io_read = 1'b0;
        step();
        check("read_end_oe", 40'(io_rdata_oe), 40'd0);
        check("read_end_data", 40'(io_rdata), 40'hFF);

        // long 30-clock write: one 8-clock pulse starting 1 clk after the write
        joy_d = 8'hF0;
        io_write = 1'b1;
        pat = '0;
        for (int i = 1; i <= 30; i++) begin
            step();
            pat[i] = joy_en;
        end
        check("single_pulse", pat, 40'h00_0000_01FE);
        io_write = 1'b0;
        steps(3);

        // re-trigger 3 clk into a pulse, then a write landing in the gap
        pat = '0;
        io_write = 1'b1; step(); pat[1] = joy_en;
        io_write = 1'b0; step(); pat[2] = joy_en;
        step(); pat[3] = joy_en;
        io_write = 1'b1; step(); pat[4] = joy_en;
        io_write = 1'b0; step(); pat[5] = joy_en;
        io_write = 1'b1; step(); pat[6] = joy_en;
        io_write = 1'b0;
        for (int i = 7; i <= 25; i++) begin
            step();
            pat[i] = joy_en;
        end
        check("retrigger_gap", pat, 40'h00_0000_3FCE);

        // mirror and miss decode
        io_addr = 16'h0207; io_read = 1'b1; steps(2);
        check("mirror_207_oe", 40'(io_rdata_oe), 40'd1);
        check("mirror_207_data", 40'(io_rdata), 40'hF0);
        io_read = 1'b0; steps(2);
        io_addr = 16'h0208; io_read = 1'b1; steps(3);
        check("miss_208_oe", 40'(io_rdata_oe), 40'd0);
        io_read = 1'b0; steps(2);
        io_addr = 16'h01FF; io_read = 1'b1; steps(3);
        check("miss_1ff_oe", 40'(io_rdata_oe), 40'd0);
        check("miss_1ff_data", 40'(io_rdata), 40'hFF);
        io_read = 1'b0; steps(2);
        io_addr = 16'h0201; enable = 1'b0; io_write = 1'b1;
        pat = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            pat[i] = joy_en;
        end
        check("disabled_write", pat, 40'd0);
        io_write = 1'b0; enable = 1'b1; steps(2);

        // timeout: axes 1:0 stuck high get masked 100 clk after the trigger
        joy_d = 8'hB3;
        io_write = 1'b1; step();
        io_write = 1'b0;
        check("to_busy_start", 40'(busy), 40'd1);
        steps(98);
        check("to_busy_99", 40'(busy), 40'd1);
        steps(4);
        check("to_busy_103", 40'(busy), 40'd0);
        io_read = 1'b1; step();
        check("to_masked_read", 40'(io_rdata), 40'hB0);
        io_read = 1'b0; step();
        io_write = 1'b1; step();
        io_write = 1'b0;
        check("to_mask_cleared_busy", 40'(busy), 40'd1);
        io_read = 1'b1; step();
        check("to_mask_cleared_read", 40'(io_rdata), 40'hB3);
        io_read = 1'b0; steps(12);

        // snapshot stays fixed while joy_d changes mid-read
        joy_d = 8'hF0;
        io_read = 1'b1; step();
        check("snap_first", 40'(io_rdata), 40'hF0);
        joy_d = 8'h0F; steps(5);
        check("snap_hold", 40'(io_rdata), 40'hF0);
        io_read = 1'b0; step();
        io_read = 1'b1; step();
        check("snap_new_read", 40'(io_rdata), 40'h0F);
        io_read = 1'b0; steps(2);

        // simultaneous read and write start: read sees pre-trigger joy_d
        joy_d = 8'hF5;
        io_read = 1'b1; io_write = 1'b1; step();
        check("simul_read", 40'(io_rdata), 40'hF5);
        check("simul_joy_en", 40'(joy_en), 40'd1);
        io_read = 1'b0; io_write = 1'b0; steps(12);

        // reset in the middle of a pulse
        io_write = 1'b1; steps(2);
        io_write = 1'b0;
        check("pre_reset_joy_en", 40'(joy_en), 40'd1);
        reset = 1'b1; step();
        check("mid_reset_joy_en", 40'(joy_en), 40'd0);
        check("mid_reset_busy", 40'(busy), 40'd0);
        reset = 1'b0; step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
